// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus arbiter and its helpers.
// Access size is carried as a 2-bit code and decoded back to w/hw at the slave port.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    typedef logic [1:0] acc_size_t;

    localparam acc_size_t SIZE_BYTE = 2'd0;
    localparam acc_size_t SIZE_HALF = 2'd1;
    localparam acc_size_t SIZE_WORD = 2'd2;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hdead_beef;

    // Word wins if a master sets both size bits.
    function automatic acc_size_t size_enc(input logic w, input logic hw);
        acc_size_t s;
        if (w) begin
            s = SIZE_WORD;
        end else if (hw) begin
            s = SIZE_HALF;
        end else begin
            s = SIZE_BYTE;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr (mod N),
// returned both one-hot and as an index.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master round-robin arbiter in front of the single QSPI read/write port:
// one latched transaction at a time, with response timeout and error pulse.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned       NUM_MASTERS = 3,
    parameter int unsigned       ADR_W       = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       TIMEOUT     = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(DEFAULT_ERR_DATA)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS-1:0]        m_w,
    input  logic [NUM_MASTERS-1:0]        m_hw,
    input  logic [NUM_MASTERS*ADR_W-1:0]  m_adr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_grant,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          read_req,
    output logic                          write_req,
    output logic                          read_w,
    output logic                          read_hw,
    output logic                          write_w,
    output logic                          write_hw,
    output logic [ADR_W-1:0]              read_adr,
    output logic [ADR_W-1:0]              write_adr,
    output logic [DATA_W-1:0]             write_data,
    input  logic                          read_valid,
    input  logic [DATA_W-1:0]             read_data,
    input  logic                          write_finish
);

    localparam int unsigned      IDX_W    = $clog2(NUM_MASTERS);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    we_q, we_d;
    acc_size_t               size_q, size_d;
    logic [ADR_W-1:0]        adr_q, adr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    arm_q, arm_d;

    logic [NUM_MASTERS-1:0]  pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    resp;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IDX_W)
    ) u_rr_pick (
        .req (m_req),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign resp = we_q ? write_finish : read_valid;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        we_d    = we_q;
        size_d  = size_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        arm_d   = arm_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    idx_d   = pick_idx;
                    we_d    = m_we[pick_idx];
                    size_d  = size_enc(m_w[pick_idx], m_hw[pick_idx]);
                    adr_d   = m_adr[pick_idx*ADR_W +: ADR_W];
                    wdata_d = m_wdata[pick_idx*DATA_W +: DATA_W];
                    err_d   = 1'b0;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                cnt_d   = '0;
                arm_d   = 1'b0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                // Counting starts one WAIT cycle late so the abort lands
                // TIMEOUT+2 cycles after the slave request pulse.
                if (resp) begin
                    if (!we_q) begin
                        rdata_d = read_data;
                    end
                    state_d = ARB_DONE;
                end else if (!arm_q) begin
                    arm_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                    err_d   = 1'b1;
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_DONE: begin
                grant_d = '0;
                rr_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            size_q  <= size_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
        end
    end

    assign m_grant    = grant_q;
    assign m_done     = (state_q == ARB_DONE) ? grant_q : '0;
    assign m_err      = (state_q == ARB_DONE && err_q) ? grant_q : '0;
    assign m_rdata    = rdata_q;
    assign read_req   = (state_q == ARB_ISSUE) && !we_q;
    assign write_req  = (state_q == ARB_ISSUE) && we_q;
    assign read_w     = (size_q == SIZE_WORD);
    assign read_hw    = (size_q == SIZE_HALF);
    assign write_w    = (size_q == SIZE_WORD);
    assign write_hw   = (size_q == SIZE_HALF);
    assign read_adr   = adr_q;
    assign write_adr  = adr_q;
    assign write_data = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a transaction model.
module tb_mem_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam logic [31:0] ERRD = 32'hdeadbeef;

    logic            clk = 1'b0;
    logic            rst;
    logic [NM-1:0]   m_req, m_we, m_w, m_hw;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]   m_grant, m_done, m_err;
    logic [DW-1:0]   m_rdata;
    logic            read_req, write_req, read_w, read_hw, write_w, write_hw;
    logic [AW-1:0]   read_adr, write_adr;
    logic [DW-1:0]   write_data;
    logic            read_valid, write_finish;
    logic [DW-1:0]   read_data;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .NUM_MASTERS (NM),
        .ADR_W       (AW),
        .DATA_W      (DW),
        .TIMEOUT     (TO),
        .ERR_DATA    (ERRD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_w          (m_w),
        .m_hw         (m_hw),
        .m_adr        (m_adr),
        .m_wdata      (m_wdata),
        .m_grant      (m_grant),
        .m_done       (m_done),
        .m_err        (m_err),
        .m_rdata      (m_rdata),
        .read_req     (read_req),
        .write_req    (write_req),
        .read_w       (read_w),
        .read_hw      (read_hw),
        .write_w      (write_w),
        .write_hw     (write_hw),
        .read_adr     (read_adr),
        .write_adr    (write_adr),
        .write_data   (write_data),
        .read_valid   (read_valid),
        .read_data    (read_data),
        .write_finish (write_finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who owns the bus, how many cycles since the
    // slave request pulse (age), and whether the transaction has finished.
    bit          mbusy = 0, mfin = 0, merr = 0;
    int          mown = 0, mage = 0, mrr = 0;
    logic        mwe = 0, mw = 0, mhw = 0;
    logic [31:0] madr = '0, mwd = '0, mrd = '0;

    initial forever begin
        bit found;
        @(posedge clk);
        if (rst) begin
            mbusy = 0; mfin = 0; merr = 0; mrr = 0; mage = 0;
            mrd = '0; madr = '0; mwd = '0; mwe = 0; mw = 0; mhw = 0;
        end else if (!mbusy) begin
            found = 0;
            for (int k = 0; k < NM; k++) begin
                if (!found && m_req[(mrr + k) % NM]) begin
                    found = 1;
                    mown = (mrr + k) % NM;
                end
            end
            if (found) begin
                mbusy = 1; mfin = 0; merr = 0; mage = 0;
                mwe  = m_we[mown];
                mw   = m_w[mown];
                mhw  = m_hw[mown];
                madr = m_adr[mown*AW +: AW];
                mwd  = m_wdata[mown*DW +: DW];
            end
        end else if (mfin) begin
            mbusy = 0;
            mrr = (mown + 1) % NM;
        end else begin
            if (mage >= 1 && (mwe ? write_finish : read_valid)) begin
                mfin = 1;
                if (!mwe) mrd = read_data;
            end else if (mage == TO + 1) begin
                mfin = 1;
                merr = 1;
                if (!mwe) mrd = ERRD;
            end
            mage++;
        end
    end

    initial forever begin
        logic [NM-1:0] oh;
        @(negedge clk);
        oh = mbusy ? NM'(1) << mown : '0;
        chk("grant", m_grant, oh);
        chk("done", m_done, (mbusy && mfin) ? oh : '0);
        chk("err", m_err, (mbusy && mfin && merr) ? oh : '0);
        chk("read_req", read_req, mbusy && !mfin && mage == 0 && !mwe);
        chk("write_req", write_req, mbusy && !mfin && mage == 0 && mwe);
        chk("rdata", m_rdata, mrd);
        chk("read_adr", read_adr, madr);
        chk("write_adr", write_adr, madr);
        chk("write_data", write_data, mwd);
        chk("read_w", read_w, mw);
        chk("write_w", write_w, mw);
        chk("read_hw", read_hw, mhw);
        chk("write_hw", write_hw, mhw);
    end

    task automatic set_master(input int i, input logic we, input logic w, input logic hw,
                              input logic [31:0] adr, input logic [31:0] wd);
        m_we[i] = we;
        m_w[i]  = w;
        m_hw[i] = hw;
        m_adr[i*AW +: AW]   = adr;
        m_wdata[i*DW +: DW] = wd;
        m_req[i] = 1'b1;
    endtask

    task automatic issue_wait();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(read_req || write_req) && n < 10);
        chk("issue_seen", read_req | write_req, 1);
    endtask

    int rr_exp [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        logic [NM-1:0] exp_oh;
        int n;
        rst = 1; m_req = '0; m_we = '0; m_w = '0; m_hw = '0;
        m_adr = '0; m_wdata = '0; read_valid = 0; write_finish = 0; read_data = '0;
        repeat (3) tick();
        rst = 0;
        chk("rst_grant", m_grant, 0);
        chk("rst_done", m_done, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_adr", read_adr, 0);
        chk("rst_req", read_req | write_req, 0);

        // Single word read by master 1, slave answers 3 cycles after read_req.
        set_master(1, 0, 1, 0, 32'h0000_0100, 32'h0);
        tick();
        chk("rd_grant", m_grant, 3'b010);
        chk("rd_req", read_req, 1);
        chk("rd_adr", read_adr, 32'h100);
        chk("rd_w", read_w, 1);
        repeat (3) tick();
        read_valid = 1; read_data = 32'h1234_5678;
        tick();
        read_valid = 0; m_req[1] = 0;
        chk("rd_done", m_done, 3'b010);
        chk("rd_rdata", m_rdata, 32'h1234_5678);
        chk("rd_err", m_err, 0);
        tick();
        chk("rd_release", m_grant, 0);

        // Halfword write by master 2; a wrong-kind response must be ignored.
        set_master(2, 1, 0, 1, 32'h0000_0200, 32'h0000_beef);
        tick();
        chk("wr_req", write_req, 1);
        chk("wr_hw", write_hw, 1);
        chk("wr_data", write_data, 32'h0000_beef);
        chk("wr_adr", write_adr, 32'h200);
        m_adr[2*AW +: AW] = 32'hffff_ffff;
        m_wdata[2*DW +: DW] = 32'h1111_1111;
        tick();
        read_valid = 1; read_data = 32'haaaa_aaaa;
        chk("wr_latched", write_adr, 32'h200);
        tick();
        read_valid = 0; write_finish = 1;
        chk("wr_no_early_done", m_done, 0);
        tick();
        write_finish = 0; m_req[2] = 0;
        chk("wr_done", m_done, 3'b100);
        chk("wr_rdata_kept", m_rdata, 32'h1234_5678);
        tick();

        // All three masters request continuously.
        for (int i = 0; i < NM; i++) set_master(i, 0, 1, 0, 32'h1000 + 32'(i), 32'h0);
        for (int t = 0; t < 6; t++) begin
            issue_wait();
            exp_oh = NM'(1) << rr_exp[t];
            chk("rr_order", m_grant, exp_oh);
            tick();
            read_valid = 1; read_data = $urandom;
            tick();
            read_valid = 0;
            chk("rr_done", m_done, exp_oh);
        end
        m_req = '0;
        tick();

        // Timeout on a read by master 0, then master 1 served normally.
        set_master(0, 0, 1, 0, 32'h40, 32'h0);
        issue_wait();
        chk("to_grant", m_grant, 3'b001);
        n = 0;
        while (m_done == 0 && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n, 18);
        chk("to_done", m_done, 3'b001);
        chk("to_err", m_err, 3'b001);
        chk("to_rdata", m_rdata, 32'hdeadbeef);
        m_req[0] = 0;
        set_master(1, 0, 1, 0, 32'h44, 32'h0);
        issue_wait();
        chk("after_to_grant", m_grant, 3'b010);
        tick();
        tick();
        read_valid = 1; read_data = 32'h0bad_f00d;
        tick();
        read_valid = 0; m_req[1] = 0;
        chk("after_to_done", m_done, 3'b010);
        chk("after_to_err", m_err, 0);
        chk("after_to_rdata", m_rdata, 32'h0bad_f00d);
        tick();

        // Reset while master 2 waits for read data; late response is stale.
        set_master(2, 0, 1, 0, 32'h300, 32'h0);
        issue_wait();
        tick();
        rst = 1; m_req = '0;
        tick();
        rst = 0; read_valid = 1; read_data = 32'h55;
        chk("mid_rst_grant", m_grant, 0);
        chk("mid_rst_done", m_done, 0);
        chk("mid_rst_rdata", m_rdata, 0);
        tick();
        read_valid = 0;
        chk("stale_done", m_done, 0);
        tick();
        chk("stale_done2", m_done, 0);
        set_master(1, 0, 1, 0, 32'h500, 32'h0);
        set_master(2, 0, 1, 0, 32'h600, 32'h0);
        issue_wait();
        chk("post_rst_grant", m_grant, 3'b010);
        chk("post_rst_adr", read_adr, 32'h500);
        tick();
        read_valid = 1; read_data = 32'h77;
        tick();
        read_valid = 0; m_req = '0;
        chk("post_rst_done", m_done, 3'b010);
        chk("post_rst_rdata", m_rdata, 32'h77);
        tick();

        // Randomized traffic; quiet slave windows force timeouts.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit quiet;
            int r;
            quiet = ((cyc / 300) % 4 == 3);
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < NM; i++) begin
                if (m_req[i]) begin
                    if (m_done[i] && $urandom_range(0, 1) == 0) m_req[i] = 0;
                    else if (!m_grant[i] && $urandom_range(0, 31) == 0) m_req[i] = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    m_req[i] = 1;
                end
                r = $urandom_range(0, 2);
                m_we[i] = $urandom_range(0, 1) == 1;
                m_w[i]  = (r == 2);
                m_hw[i] = (r == 1);
                m_adr[i*AW +: AW]   = $urandom;
                m_wdata[i*DW +: DW] = $urandom;
            end
            read_valid   = !quiet && ($urandom_range(0, 4) == 0);
            write_finish = !quiet && ($urandom_range(0, 4) == 0);
            read_data    = $urandom;
            tick();
        end
        rst = 0; m_req = '0; read_valid = 0; write_finish = 0;
        repeat (TO + 10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
